instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 35 +++
 rtl/instr_fetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: run control, PC inputs, byte loader handshake and IF/ID outputs.
// The pipeline/debug side uses the master modport; instr_fetch uses slave.
interface instr_fetch_if #(
   parameter int SIZE_ADDR_PC = 32,
   parameter int SIZE_INST    = 32
);
   logic                    i_start;
   logic                    i_step;
   logic [SIZE_ADDR_PC-1:0] i_pc;
   logic [SIZE_ADDR_PC-1:0] i_pc_4;
   logic                    i_stall;
   logic                    i_flush;
   logic                    i_load_en;
   logic [7:0]              i_load_byte;
   logic                    i_load_valid;
   logic                    o_load_ready;
   logic [SIZE_INST-1:0]    o_instr;
   logic [SIZE_ADDR_PC-1:0] o_pc_4;
   logic                    o_valid;
   logic                    o_pc_write;
   logic                    o_halt;
   logic                    o_fault;

   modport master (
      output i_start, i_step, i_pc, i_pc_4, i_stall, i_flush,
             i_load_en, i_load_byte, i_load_valid,
      input  o_load_ready, o_instr, o_pc_4, o_valid, o_pc_write, o_halt, o_fault
   );

   modport slave (
      input  i_start, i_step, i_pc, i_pc_4, i_stall, i_flush,
             i_load_en, i_load_byte, i_load_valid,
      output o_load_ready, o_instr, o_pc_4, o_valid, o_pc_write, o_halt, o_fault
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage with a byte-loaded instruction memory and IDLE/LOAD/RUN/HALT control.
// Optional macro FETCH_RANGE_CHECK_EN: fault and halt on fetches beyond the loaded words.
// The byte loader packs four bytes per word, so SIZE_INST is expected to be 32.
module instr_fetch #(
   parameter int SIZE_ADDR_PC = 32,
   parameter int SIZE_INST    = 32,
   parameter int MEM_DEPTH    = 256
) (
   input logic          i_clk,
   input logic          i_reset,
   instr_fetch_if.slave bus
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [AW:0]          WORDS_MAX = (AW+1)'(MEM_DEPTH);
   localparam logic [SIZE_INST-1:0] HALT_WORD = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_HALT
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [SIZE_INST-1:0]    mem [MEM_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW:0]             words_loaded;
   logic [1:0]              byte_cnt;
   logic [23:0]             byte_buf;
   logic [SIZE_INST-1:0]    instr_q;
   logic [SIZE_ADDR_PC-1:0] pc_4_q;
   logic                    valid_q;
   logic [AW-1:0]           rd_idx;
   logic [SIZE_INST-1:0]    fetch_word;
   logic                    in_range;
   logic                    fetch_go;
   logic                    load_accept;
   logic                    word_done;
   logic                    unused_pc;

   assign rd_idx     = bus.i_pc[AW+1:2];
   assign fetch_word = mem[rd_idx];
   assign word_done  = load_accept && (byte_cnt == 2'd3);
   assign unused_pc  = ^{bus.i_pc[SIZE_ADDR_PC-1:AW+2], bus.i_pc[1:0]};

   // NOTE: every signal written here gets a default first so no latch can be inferred.
   always_comb begin
      state_nxt   = state;
      fetch_go    = 1'b0;
      load_accept = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.i_load_en)    state_nxt = S_LOAD;
            else if (bus.i_start) state_nxt = S_RUN;
         end
         S_LOAD: begin
            load_accept = bus.i_load_en && bus.i_load_valid;
            if (!bus.i_load_en) state_nxt = S_IDLE;
         end
         S_RUN: begin
            if (!bus.i_flush && bus.i_step && !bus.i_stall) begin
               fetch_go = 1'b1;
               if (!in_range || fetch_word == HALT_WORD) state_nxt = S_HALT;
            end
         end
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Ready drops together with i_load_en so no byte lands on the exit edge.
   assign bus.o_load_ready = (state == S_LOAD) && bus.i_load_en;
   assign bus.o_pc_write   = (state == S_RUN) && bus.i_step && !bus.i_stall &&
                             (state_nxt != S_HALT);
   assign bus.o_halt       = (state == S_HALT);
   assign bus.o_instr      = instr_q;
   assign bus.o_pc_4       = pc_4_q;
   assign bus.o_valid      = valid_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state        <= S_IDLE;
         instr_q      <= '0;
         pc_4_q       <= '0;
         valid_q      <= 1'b0;
         wr_ptr       <= '0;
         words_loaded <= '0;
         byte_cnt     <= '0;
         byte_buf     <= '0;
      end else begin
         state <= state_nxt;

         if (state == S_IDLE && state_nxt == S_LOAD) begin
            wr_ptr       <= '0;
            words_loaded <= '0;
            byte_cnt     <= '0;
         end

         // Leaving LOAD throws away any partially assembled word.
         if (state == S_LOAD && !bus.i_load_en) byte_cnt <= '0;

         if (load_accept) begin
            if (word_done) begin
               byte_cnt <= '0;
               wr_ptr   <= wr_ptr + 1'b1;
               if (words_loaded != WORDS_MAX) words_loaded <= words_loaded + 1'b1;
            end else begin
               byte_buf <= {byte_buf[15:0], bus.i_load_byte};
               byte_cnt <= byte_cnt + 2'd1;
            end
         end

         if (state == S_RUN) begin
            if (bus.i_flush) begin
               instr_q <= '0;
               valid_q <= 1'b0;
            end else if (fetch_go) begin
               if (in_range) begin
                  instr_q <= fetch_word;
                  pc_4_q  <= bus.i_pc_4;
                  valid_q <= 1'b1;
               end else begin
                  instr_q <= '0;
                  valid_q <= 1'b0;
               end
            end
         end
      end
   end

   // NOTE: the instruction memory is deliberately not reset; its contents survive
   // everything except a LOAD, and write enables are already quiet under reset.
   always_ff @(posedge i_clk) begin
      if (word_done) mem[wr_ptr] <= {byte_buf, bus.i_load_byte};
   end

`ifdef FETCH_RANGE_CHECK_EN
   logic fault_q;

   assign in_range    = ({1'b0, rd_idx} < words_loaded);
   assign bus.o_fault = fault_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)                               fault_q <= 1'b0;
      else if (state == S_RUN && !bus.i_flush &&
               fetch_go && !in_range)             fault_q <= 1'b1;
   end
`else
   logic unused_words;

   assign in_range     = 1'b1;
   assign bus.o_fault  = 1'b0;
   assign unused_words = ^words_loaded;
`endif

endmodule
